mem_access: RTL

Memory-access pipeline stage between the execute stage and the `wb` stage. It accepts one instruction per cycle, turns loads and stores into data-bus transactions with correct word address, byte enables and store-data lane placement, and waits out bus wait states while stalling upstream. It detects alignment errors and registers everything `wb` needs: raw read word, address, pass-through data, destination register, access op/size, unsigned flag and exception flag.

---
 rtl/mem_access_if.sv | 20 ++
 rtl/mem_access.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Data-bus connection between the memory-access stage (master) and data memory (slave).
interface mem_access_if;
   logic [31:0] dbus_address;
   logic [3:0]  dbus_byteenable;
   logic        dbus_read;
   logic        dbus_write;
   logic [31:0] dbus_wrdata;
   logic [31:0] dbus_rddata;
   logic        dbus_stall;

   modport master (
      output dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
      input  dbus_rddata, dbus_stall
   );

   modport slave (
      input  dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
      output dbus_rddata, dbus_stall
   );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues load/store bus transactions, holds upstream
// through bus wait states and registers the fields consumed by the write-back stage.
module mem_access (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic [1:0]   mem_access_op_i,
   input  logic [2:0]   mem_access_sz_i,
   input  logic [31:0]  addr_i,
   input  logic [31:0]  data_i,
   input  logic [4:0]   reg_addr_i,
   input  logic         flag_unsigned_i,
   input  logic         exception_i,
   output logic         stall_o,
   mem_access_if.master dbus,
   output logic [1:0]   mem_access_op_o,
   output logic [2:0]   mem_access_sz_o,
   output logic [31:0]  mem_data_o,
   output logic [31:0]  addr_o,
   output logic [31:0]  data_o,
   output logic [4:0]   reg_addr_o,
   output logic         flag_unsigned_o,
   output logic         exception_det_o,
   output logic [31:0]  badvaddr_o
);
   localparam logic [1:0] ACCESS_OP_D2R   = 2'd0;
   localparam logic [1:0] ACCESS_OP_M2R   = 2'd1;
   localparam logic [1:0] ACCESS_OP_R2M   = 2'd2;
   localparam logic [2:0] ACCESS_SZ_BYTE  = 3'd0;
   localparam logic [2:0] ACCESS_SZ_HALF  = 3'd1;
   localparam logic [2:0] ACCESS_SZ_WORD  = 3'd2;
   localparam logic [2:0] ACCESS_SZ_LEFT  = 3'd3;
   localparam logic [2:0] ACCESS_SZ_RIGHT = 3'd4;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUS  = 1'b1;

   typedef struct packed {
      logic [1:0]  op;
      logic [2:0]  sz;
      logic [31:0] mem_data;
      logic [31:0] addr;
      logic [31:0] data;
      logic [4:0]  reg_addr;
      logic        flag_unsigned;
      logic        exception_det;
      logic [31:0] badvaddr;
   } wb_fields_t;

   // A bubble writes $zero, which the register file discards.
   localparam wb_fields_t BUBBLE = '{op: ACCESS_OP_D2R, sz: 3'd0, mem_data: 32'h0,
                                     addr: 32'h0, data: 32'h0, reg_addr: 5'd0,
                                     flag_unsigned: 1'b0, exception_det: 1'b0,
                                     badvaddr: 32'h0};

   logic [0:0]  state_r, state_nxt_s;
   logic        drop_r, drop_nxt_s;
   logic [31:0] req_addr_r, req_addr_nxt_s;
   logic [3:0]  req_be_r, req_be_nxt_s;
   logic [31:0] req_wrdata_r, req_wrdata_nxt_s;
   logic        req_read_r, req_read_nxt_s;
   logic        req_write_r, req_write_nxt_s;
   wb_fields_t  pend_r, pend_nxt_s;
   wb_fields_t  out_r, out_nxt_s;
   wb_fields_t  in_fields_s;

   logic        is_mem_s;
   logic        align_err_s;
   logic        start_bus_s;
   logic [1:0]  inv_a_s;
   logic [3:0]  st_be_s;
   logic [31:0] st_wrdata_s;

   // Decode: alignment check, bus start condition and incoming wb fields
   always_comb begin
      is_mem_s    = (mem_access_op_i == ACCESS_OP_M2R) || (mem_access_op_i == ACCESS_OP_R2M);
      align_err_s = 1'b0;
      if (is_mem_s) begin
         case (mem_access_sz_i)
            ACCESS_SZ_HALF: align_err_s = addr_i[0];
            ACCESS_SZ_WORD: align_err_s = (addr_i[1:0] != 2'b00);
            default:        align_err_s = 1'b0;
         endcase
      end else begin
         align_err_s = 1'b0;
      end
      start_bus_s = is_mem_s && !exception_i && !align_err_s && !flush;

      in_fields_s.op            = mem_access_op_i;
      in_fields_s.sz            = mem_access_sz_i;
      in_fields_s.mem_data      = 32'h0;
      in_fields_s.addr          = addr_i;
      in_fields_s.data          = data_i;
      in_fields_s.reg_addr      = reg_addr_i;
      in_fields_s.flag_unsigned = flag_unsigned_i;
      in_fields_s.exception_det = exception_i | align_err_s;
      in_fields_s.badvaddr      = align_err_s ? addr_i : 32'h0;
   end

   // Store lane placement: byte enables and replicated/shifted write data
   always_comb begin
      inv_a_s = 2'd3 - addr_i[1:0];
      case (mem_access_sz_i)
         ACCESS_SZ_BYTE: begin
            st_be_s     = 4'b0001 << addr_i[1:0];
            st_wrdata_s = {4{data_i[7:0]}};
         end
         ACCESS_SZ_HALF: begin
            st_be_s     = addr_i[1] ? 4'b1100 : 4'b0011;
            st_wrdata_s = {2{data_i[15:0]}};
         end
         ACCESS_SZ_WORD: begin
            st_be_s     = 4'b1111;
            st_wrdata_s = data_i;
         end
         ACCESS_SZ_LEFT: begin
            st_be_s     = 4'b1111 >> inv_a_s;
            st_wrdata_s = data_i >> {inv_a_s, 3'b000};
         end
         ACCESS_SZ_RIGHT: begin
            st_be_s     = 4'b1111 << addr_i[1:0];
            st_wrdata_s = data_i << {addr_i[1:0], 3'b000};
         end
         default: begin
            st_be_s     = 4'b0000;
            st_wrdata_s = 32'h0;
         end
      endcase
   end

   // FSM next state, bus request, pending and output register updates
   always_comb begin
      state_nxt_s      = state_r;
      drop_nxt_s       = drop_r;
      req_addr_nxt_s   = req_addr_r;
      req_be_nxt_s     = req_be_r;
      req_wrdata_nxt_s = req_wrdata_r;
      req_read_nxt_s   = req_read_r;
      req_write_nxt_s  = req_write_r;
      pend_nxt_s       = pend_r;
      out_nxt_s        = out_r;
      case (state_r)
         IDLE: begin
            drop_nxt_s = 1'b0;
            if (flush) begin
               out_nxt_s = BUBBLE;
            end else if (start_bus_s) begin
               state_nxt_s      = BUS;
               pend_nxt_s       = in_fields_s;
               out_nxt_s        = BUBBLE;
               req_addr_nxt_s   = {addr_i[31:2], 2'b00};
               req_read_nxt_s   = (mem_access_op_i == ACCESS_OP_M2R);
               req_write_nxt_s  = (mem_access_op_i == ACCESS_OP_R2M);
               req_be_nxt_s     = req_read_nxt_s ? 4'b1111 : st_be_s;
               req_wrdata_nxt_s = req_read_nxt_s ? 32'h0 : st_wrdata_s;
            end else begin
               out_nxt_s = in_fields_s;
            end
         end
         BUS: begin
            if (dbus.dbus_stall) begin
               drop_nxt_s = drop_r | flush;
            end else begin
               state_nxt_s     = IDLE;
               drop_nxt_s      = 1'b0;
               req_read_nxt_s  = 1'b0;
               req_write_nxt_s = 1'b0;
               if (flush || drop_r) begin
                  out_nxt_s = BUBBLE;
               end else begin
                  out_nxt_s          = pend_r;
                  out_nxt_s.mem_data = (pend_r.op == ACCESS_OP_M2R) ? dbus.dbus_rddata : 32'h0;
               end
            end
         end
         default: begin
            state_nxt_s     = IDLE;
            drop_nxt_s      = 1'b0;
            req_read_nxt_s  = 1'b0;
            req_write_nxt_s = 1'b0;
            out_nxt_s       = BUBBLE;
         end
      endcase
   end

   // State, request, pending and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         drop_r       <= 1'b0;
         req_addr_r   <= 32'h0;
         req_be_r     <= 4'b0000;
         req_wrdata_r <= 32'h0;
         req_read_r   <= 1'b0;
         req_write_r  <= 1'b0;
         pend_r       <= BUBBLE;
         out_r        <= BUBBLE;
      end else begin
         state_r      <= state_nxt_s;
         drop_r       <= drop_nxt_s;
         req_addr_r   <= req_addr_nxt_s;
         req_be_r     <= req_be_nxt_s;
         req_wrdata_r <= req_wrdata_nxt_s;
         req_read_r   <= req_read_nxt_s;
         req_write_r  <= req_write_nxt_s;
         pend_r       <= pend_nxt_s;
         out_r        <= out_nxt_s;
      end
   end

   assign stall_o              = (state_r == BUS);
   assign dbus.dbus_address    = req_addr_r;
   assign dbus.dbus_byteenable = req_be_r;
   assign dbus.dbus_wrdata     = req_wrdata_r;
   assign dbus.dbus_read       = req_read_r;
   assign dbus.dbus_write      = req_write_r;

   assign mem_access_op_o = out_r.op;
   assign mem_access_sz_o = out_r.sz;
   assign mem_data_o      = out_r.mem_data;
   assign addr_o          = out_r.addr;
   assign data_o          = out_r.data;
   assign reg_addr_o      = out_r.reg_addr;
   assign flag_unsigned_o = out_r.flag_unsigned;
   assign exception_det_o = out_r.exception_det;
   assign badvaddr_o      = out_r.badvaddr;
endmodule
